// File: rtl/ysyx_22041412_csr_pkg.sv
//============================================================================
// Module  : ysyx_22041412_csr_pkg
// Brief   : CSR addresses, request kinds, func3 codes and mstatus field map.
// Rev     : 1.0
//============================================================================
`default_nettype none

package ysyx_22041412_csr_pkg;

   localparam logic [11:0] c_csr_mstatus  = 12'h300;
   localparam logic [11:0] c_csr_mtvec    = 12'h305;
   localparam logic [11:0] c_csr_mscratch = 12'h340;
   localparam logic [11:0] c_csr_mepc     = 12'h341;
   localparam logic [11:0] c_csr_mcause   = 12'h342;
   localparam logic [11:0] c_csr_mcycle   = 12'hB00;
   localparam logic [11:0] c_csr_mcycleh  = 12'hB80;

   typedef enum logic [1:0] {
      KIND_CSR   = 2'd0,
      KIND_ECALL = 2'd1,
      KIND_MRET  = 2'd2,
      KIND_RSVD  = 2'd3
   } kind_e;

   localparam logic [2:0] c_f3_csrrw  = 3'b001;
   localparam logic [2:0] c_f3_csrrs  = 3'b010;
   localparam logic [2:0] c_f3_csrrc  = 3'b011;
   localparam logic [2:0] c_f3_csrrwi = 3'b101;
   localparam logic [2:0] c_f3_csrrsi = 3'b110;
   localparam logic [2:0] c_f3_csrrci = 3'b111;

   localparam int c_mcause_ecall_m = 11;

   localparam int c_mstatus_mie    = 3;
   localparam int c_mstatus_mpie   = 7;
   localparam int c_mstatus_mpp_lo = 11;
   localparam int c_mstatus_mpp_hi = 12;

   // Only 000 and 100 are non-CSR encodings in the SYSTEM opcode space.
   function automatic logic func3_legal(input logic [2:0] f3);
      return f3[1:0] != 2'b00;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22041412_csr_if.sv
//============================================================================
// Module  : ysyx_22041412_csr_if
// Brief   : EXU <-> CSR file request/response bundle with valid/ready/done.
// Rev     : 1.0
//============================================================================
`default_nettype none

interface ysyx_22041412_csr_if #(
   parameter int XLEN = 64
);
   logic            valid_i;
   logic            ready_o;
   logic [1:0]      kind_i;
   logic [2:0]      func3_i;
   logic [11:0]     addr_i;
   logic [XLEN-1:0] pc_i;
   logic [XLEN-1:0] wdata_i;
   logic [XLEN-1:0] rdata_o;
   logic            done_o;
   logic            illegal_o;

   modport slave (
      input  valid_i, kind_i, func3_i, addr_i, pc_i, wdata_i,
      output ready_o, rdata_o, done_o, illegal_o
   );

   modport master (
      output valid_i, kind_i, func3_i, addr_i, pc_i, wdata_i,
      input  ready_o, rdata_o, done_o, illegal_o
   );
endinterface

`default_nettype wire

// File: rtl/ysyx_22041412_csr_alu.sv
//============================================================================
// Module  : ysyx_22041412_csr_alu
// Brief   : Combinational CSR read-modify-write; zero set/clear operand
//           suppresses the write.
// Rev     : 1.0
//============================================================================
`default_nettype none

module ysyx_22041412_csr_alu
   import ysyx_22041412_csr_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [2:0]      i_func3,
   input  logic [XLEN-1:0] i_old,
   input  logic [XLEN-1:0] i_operand,
   output logic [XLEN-1:0] o_new,
   output logic            o_we
);

   always_comb begin
      o_new = i_old;
      o_we  = 1'b0;
      case (i_func3)
         c_f3_csrrw, c_f3_csrrwi: begin
            o_new = i_operand;
            o_we  = 1'b1;
         end
         c_f3_csrrs, c_f3_csrrsi: begin
            o_new = i_old | i_operand;
            o_we  = |i_operand;
         end
         c_f3_csrrc, c_f3_csrrci: begin
            o_new = i_old & ~i_operand;
            o_we  = |i_operand;
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/ysyx_22041412_csr_file.sv
//============================================================================
// Module  : ysyx_22041412_csr_file
// Brief   : Machine-mode CSR file and ECALL/MRET trap unit.
//           Optional mcycle counter: define YSYX_22041412_MCYCLE_EN.
// Rev     : 1.0
//============================================================================
`default_nettype none

module ysyx_22041412_csr_file
   import ysyx_22041412_csr_pkg::*;
#(
   parameter int              XLEN        = 64,
   parameter logic [63:0]     MSTATUS_RST = 64'h0000000a00001800,
   parameter logic [XLEN-1:0] MTVEC_RST   = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   ysyx_22041412_csr_if.slave        bus
);

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_rmw  = 2'd1;
   localparam logic [1:0] c_st_done = 2'd2;

   localparam logic [XLEN-1:0] c_align_mask  = {{(XLEN-2){1'b1}}, 2'b00};
   localparam logic [XLEN-1:0] c_mstatus_rst = MSTATUS_RST[XLEN-1:0];

   logic [1:0]      r_state;
   logic [1:0]      w_state_nxt;
   logic [XLEN-1:0] r_mstatus;
   logic [XLEN-1:0] r_mtvec;
   logic [XLEN-1:0] r_mscratch;
   logic [XLEN-1:0] r_mepc;
   logic [XLEN-1:0] r_mcause;
   logic [XLEN-1:0] r_rdata;
   logic            r_illegal;
   logic [11:0]     r_wr_addr;
   logic [XLEN-1:0] r_wr_data;
   logic            r_wr_en;
   logic [XLEN-1:0] w_old;
   logic            w_addr_ok;
   logic [XLEN-1:0] w_new;
   logic            w_we;
   logic            w_accept;
   logic            w_csr_ok;
   logic            w_ready;
   logic            w_done;
   logic            w_commit;

`ifdef YSYX_22041412_MCYCLE_EN
   logic [63:0]     r_mcycle;
   logic [63:0]     w_mcycle_wval;
   logic            w_mcycle_wr;
   logic [XLEN-1:0] w_mcycle_rd_lo;
   logic [XLEN-1:0] w_mcycle_rd_hi;
   logic            w_mcycleh_ok;

   // RV32 splits the counter across mcycle/mcycleh; RV64 sees it whole.
   if (XLEN == 32) begin : g_mcycle_32
      assign w_mcycle_wval  = (r_wr_addr == c_csr_mcycleh) ? {r_wr_data, r_mcycle[31:0]}
                                                           : {r_mcycle[63:32], r_wr_data};
      assign w_mcycle_wr    = (r_wr_addr == c_csr_mcycle) || (r_wr_addr == c_csr_mcycleh);
      assign w_mcycle_rd_lo = r_mcycle[31:0];
      assign w_mcycle_rd_hi = r_mcycle[63:32];
      assign w_mcycleh_ok   = 1'b1;
   end else begin : g_mcycle_64
      assign w_mcycle_wval  = r_wr_data;
      assign w_mcycle_wr    = (r_wr_addr == c_csr_mcycle);
      assign w_mcycle_rd_lo = r_mcycle;
      assign w_mcycle_rd_hi = '0;
      assign w_mcycleh_ok   = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mcycle <= '0;
      end else if (w_commit && w_mcycle_wr) begin
         r_mcycle <= w_mcycle_wval;
      end else begin
         r_mcycle <= r_mcycle + 64'd1;
      end
   end
`endif

   always_comb begin
      w_old     = '0;
      w_addr_ok = 1'b1;
      case (bus.addr_i)
         c_csr_mstatus:  w_old = r_mstatus;
         c_csr_mtvec:    w_old = r_mtvec;
         c_csr_mscratch: w_old = r_mscratch;
         c_csr_mepc:     w_old = r_mepc;
         c_csr_mcause:   w_old = r_mcause;
`ifdef YSYX_22041412_MCYCLE_EN
         c_csr_mcycle:   w_old = w_mcycle_rd_lo;
         c_csr_mcycleh: begin
            w_old     = w_mcycle_rd_hi;
            w_addr_ok = w_mcycleh_ok;
         end
`endif
         default:        w_addr_ok = 1'b0;
      endcase
   end

   ysyx_22041412_csr_alu #(
      .XLEN (XLEN)
   ) u_alu (
      .i_func3   (bus.func3_i),
      .i_old     (w_old),
      .i_operand (bus.wdata_i),
      .o_new     (w_new),
      .o_we      (w_we)
   );

   assign w_accept = (r_state == c_st_idle) && bus.valid_i;
   assign w_csr_ok = (bus.kind_i == KIND_CSR) && func3_legal(bus.func3_i) && w_addr_ok;
   assign w_commit = (r_state == c_st_rmw) && r_wr_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle: if (bus.valid_i) w_state_nxt = w_csr_ok ? c_st_rmw : c_st_done;
         c_st_rmw:  w_state_nxt = c_st_idle;
         c_st_done: w_state_nxt = c_st_idle;
         default:   w_state_nxt = c_st_idle;
      endcase
   end

   always_comb begin
      w_ready = (r_state == c_st_idle);
      w_done  = (r_state == c_st_rmw) || (r_state == c_st_done);
   end

   // Traps commit on the accept edge; CSR writes wait for the RMW edge so a
   // reset during RMW drops them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mstatus  <= c_mstatus_rst;
         r_mtvec    <= MTVEC_RST;
         r_mscratch <= '0;
         r_mepc     <= '0;
         r_mcause   <= '0;
         r_rdata    <= '0;
         r_illegal  <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_wr_en    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_rdata   <= '0;
            r_illegal <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= bus.addr_i;
            r_wr_data <= w_new;
            case (kind_e'(bus.kind_i))
               KIND_CSR: begin
                  if (w_csr_ok) begin
                     r_rdata <= w_old;
                     r_wr_en <= w_we;
                  end else begin
                     r_illegal <= 1'b1;
                  end
               end
               KIND_ECALL: begin
                  r_rdata                    <= r_mtvec & c_align_mask;
                  r_mepc                     <= bus.pc_i & c_align_mask;
                  r_mcause                   <= XLEN'(c_mcause_ecall_m);
                  r_mstatus[c_mstatus_mpie]  <= r_mstatus[c_mstatus_mie];
                  r_mstatus[c_mstatus_mie]   <= 1'b0;
                  r_mstatus[c_mstatus_mpp_hi:c_mstatus_mpp_lo] <= 2'b11;
               end
               KIND_MRET: begin
                  r_rdata                    <= r_mepc;
                  r_mstatus[c_mstatus_mie]   <= r_mstatus[c_mstatus_mpie];
                  r_mstatus[c_mstatus_mpie]  <= 1'b1;
                  r_mstatus[c_mstatus_mpp_hi:c_mstatus_mpp_lo] <= 2'b11;
               end
               default: r_illegal <= 1'b1;
            endcase
         end
         if (w_commit) begin
            case (r_wr_addr)
               c_csr_mstatus:  r_mstatus  <= r_wr_data;
               c_csr_mtvec:    r_mtvec    <= r_wr_data & c_align_mask;
               c_csr_mscratch: r_mscratch <= r_wr_data;
               c_csr_mepc:     r_mepc     <= r_wr_data & c_align_mask;
               c_csr_mcause:   r_mcause   <= r_wr_data;
               default: ;
            endcase
         end
      end
   end

   assign bus.ready_o   = w_ready;
   assign bus.done_o    = w_done;
   assign bus.rdata_o   = r_rdata;
   assign bus.illegal_o = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22041412_csr_file.sv
//============================================================================
// Module  : tb_ysyx_22041412_csr_file
// Brief   : Directed vector table plus handshake and mid-op reset sequences.
// Rev     : 1.0
//============================================================================
`default_nettype none

module tb_ysyx_22041412_csr_file;
   import ysyx_22041412_csr_pkg::*;

   localparam int XLEN = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ysyx_22041412_csr_if #(.XLEN(XLEN)) bus ();

   ysyx_22041412_csr_file #(.XLEN(XLEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]  kind;
      logic [2:0]  f3;
      logic [11:0] addr;
      logic [63:0] pc;
      logic [63:0] wdata;
      logic [63:0] exp_rdata;
      logic        exp_ill;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic add(input logic [1:0] k, input logic [2:0] f3, input logic [11:0] a,
                      input logic [63:0] pc, input logic [63:0] wd,
                      input logic [63:0] er, input logic ei);
      vec_t v;
      v.kind = k; v.f3 = f3; v.addr = a; v.pc = pc; v.wdata = wd;
      v.exp_rdata = er; v.exp_ill = ei;
      vecs.push_back(v);
   endtask

   // Called at posedge+1 with the DUT idle; returns at posedge+1 idle again.
   task automatic req(input logic [1:0] k, input logic [2:0] f3, input logic [11:0] a,
                      input logic [63:0] pc, input logic [63:0] wd,
                      output logic [63:0] rd, output logic ill, output int lat);
      bus.kind_i  = k;
      bus.func3_i = f3;
      bus.addr_i  = a;
      bus.pc_i    = pc;
      bus.wdata_i = wd;
      bus.valid_i = 1'b1;
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
      lat = 1;
      while (!bus.done_o && lat < 8) begin
         @(posedge clk); #1;
         lat++;
      end
      rd  = bus.rdata_o;
      ill = bus.illegal_o;
      @(posedge clk); #1;
   endtask

   task automatic rd_csr(input logic [11:0] a, input logic [63:0] exp, input string nm);
      logic [63:0] rd;
      logic        ill;
      int          lat;
      req(2'd0, 3'b010, a, 64'd0, 64'd0, rd, ill, lat);
      chk(nm, rd, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [63:0] rd;
      logic        ill;
      int          lat;
      bit          seen;

      bus.valid_i = 1'b0;
      bus.kind_i  = 2'd0;
      bus.func3_i = 3'b000;
      bus.addr_i  = 12'h000;
      bus.pc_i    = '0;
      bus.wdata_i = '0;
      rst = 1'b1;

      //     kind  f3      addr     pc            wdata                  exp_rdata              ill
      add(2'd0, 3'b001, 12'h305, 64'd0,        64'h80000101,          64'd0,                 1'b0);
      add(2'd0, 3'b010, 12'h305, 64'd0,        64'd0,                 64'h80000100,          1'b0);
      add(2'd0, 3'b010, 12'h300, 64'd0,        64'h8,                 64'ha00001800,         1'b0);
      add(2'd0, 3'b010, 12'h300, 64'd0,        64'd0,                 64'ha00001808,         1'b0);
      add(2'd0, 3'b001, 12'h340, 64'd0,        64'h123456789abcdef0,  64'd0,                 1'b0);
      add(2'd0, 3'b011, 12'h340, 64'd0,        64'd0,                 64'h123456789abcdef0,  1'b0);
      add(2'd0, 3'b111, 12'h340, 64'd0,        64'd0,                 64'h123456789abcdef0,  1'b0);
      add(2'd0, 3'b010, 12'h340, 64'd0,        64'd0,                 64'h123456789abcdef0,  1'b0);
      add(2'd0, 3'b011, 12'h340, 64'd0,        64'hf0,                64'h123456789abcdef0,  1'b0);
      add(2'd0, 3'b110, 12'h340, 64'd0,        64'h5,                 64'h123456789abcde00,  1'b0);
      add(2'd0, 3'b101, 12'h340, 64'd0,        64'd0,                 64'h123456789abcde05,  1'b0);
      add(2'd0, 3'b010, 12'h340, 64'd0,        64'd0,                 64'd0,                 1'b0);
      add(2'd1, 3'b000, 12'h000, 64'h80000040, 64'd0,                 64'h80000100,          1'b0);
      add(2'd0, 3'b010, 12'h341, 64'd0,        64'd0,                 64'h80000040,          1'b0);
      add(2'd0, 3'b010, 12'h342, 64'd0,        64'd0,                 64'd11,                1'b0);
      add(2'd0, 3'b010, 12'h300, 64'd0,        64'd0,                 64'ha00001880,         1'b0);
      add(2'd2, 3'b000, 12'h000, 64'd0,        64'd0,                 64'h80000040,          1'b0);
      add(2'd0, 3'b010, 12'h300, 64'd0,        64'd0,                 64'ha00001888,         1'b0);
      add(2'd0, 3'b001, 12'h7c0, 64'd0,        64'hff,                64'd0,                 1'b1);
      add(2'd0, 3'b000, 12'h340, 64'd0,        64'hff,                64'd0,                 1'b1);
      add(2'd0, 3'b100, 12'h300, 64'd0,        64'hff,                64'd0,                 1'b1);
      add(2'd3, 3'b001, 12'h340, 64'd0,        64'hff,                64'd0,                 1'b1);
      add(2'd0, 3'b001, 12'hb80, 64'd0,        64'hff,                64'd0,                 1'b1);
      add(2'd0, 3'b010, 12'h340, 64'd0,        64'd0,                 64'd0,                 1'b0);
      add(2'd0, 3'b010, 12'h300, 64'd0,        64'd0,                 64'ha00001888,         1'b0);
      add(2'd0, 3'b001, 12'h341, 64'd0,        64'h80000207,          64'h80000040,          1'b0);
      add(2'd0, 3'b010, 12'h341, 64'd0,        64'd0,                 64'h80000204,          1'b0);
      add(2'd0, 3'b001, 12'h305, 64'd0,        64'h3,                 64'h80000100,          1'b0);
      add(2'd0, 3'b010, 12'h305, 64'd0,        64'd0,                 64'd0,                 1'b0);
      add(2'd0, 3'b001, 12'h342, 64'd0,        64'hdead,              64'd11,                1'b0);
      add(2'd0, 3'b010, 12'h342, 64'd0,        64'd0,                 64'hdead,              1'b0);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready",   64'(bus.ready_o),   64'd1);
      chk("rst_done",    64'(bus.done_o),    64'd0);
      chk("rst_illegal", 64'(bus.illegal_o), 64'd0);
      chk("rst_rdata",   bus.rdata_o,        64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         req(vecs[i].kind, vecs[i].f3, vecs[i].addr, vecs[i].pc, vecs[i].wdata, rd, ill, lat);
         chk($sformatf("vec%0d_rdata", i),   rd,          vecs[i].exp_rdata);
         chk($sformatf("vec%0d_illegal", i), 64'(ill),    64'(vecs[i].exp_ill));
         chk($sformatf("vec%0d_latency", i), 64'(lat),    64'd1);
         chk($sformatf("vec%0d_ready", i),   64'(bus.ready_o), 64'd1);
      end

      // valid_i held high through the busy cycle: second request waits for IDLE.
      bus.kind_i  = 2'd0;
      bus.func3_i = 3'b001;
      bus.addr_i  = 12'h340;
      bus.wdata_i = 64'haa;
      bus.valid_i = 1'b1;
      @(posedge clk); #1;
      chk("b2b_done1",  64'(bus.done_o),  64'd1);
      chk("b2b_ready1", 64'(bus.ready_o), 64'd0);
      chk("b2b_rdata1", bus.rdata_o,      64'd0);
      bus.wdata_i = 64'hbb;
      @(posedge clk); #1;
      chk("b2b_idle_ready", 64'(bus.ready_o), 64'd1);
      chk("b2b_idle_done",  64'(bus.done_o),  64'd0);
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
      chk("b2b_done2",  64'(bus.done_o), 64'd1);
      chk("b2b_rdata2", bus.rdata_o,     64'haa);
      @(posedge clk); #1;
      rd_csr(12'h340, 64'hbb, "b2b_mscratch");

      // Reset lands in the RMW cycle of a mepc write.
      bus.kind_i  = 2'd0;
      bus.func3_i = 3'b001;
      bus.addr_i  = 12'h341;
      bus.wdata_i = 64'h1000;
      bus.valid_i = 1'b1;
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_done",  64'(bus.done_o),  64'd0);
      chk("midrst_ready", 64'(bus.ready_o), 64'd1);
      chk("midrst_rdata", bus.rdata_o,      64'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (bus.done_o) seen = 1'b1;
      end
      chk("midrst_no_done", 64'(seen), 64'd0);
      rd_csr(12'h341, 64'd0,          "midrst_mepc");
      rd_csr(12'h300, 64'ha00001800,  "midrst_mstatus");
      rd_csr(12'h305, 64'd0,          "midrst_mtvec");
      rd_csr(12'h340, 64'd0,          "midrst_mscratch");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
